// File: rtl/sw_reader_pkg.sv
// Shared types and default constants for the switch-bus reader.
package sw_reader_pkg;

   localparam int unsigned SW_WIDTH          = 8;
   localparam int unsigned SW_SYNC_STAGES    = 2;
   localparam int unsigned SW_DEBOUNCE_SIM   = 4;
   localparam int unsigned SW_DEBOUNCE_BOARD = 1_000_000;

   typedef enum logic [0:0] {
      StIdle,
      StPending
   } sw_state_e;

endpackage

// File: rtl/sw_reader_if.sv
// Single-entry switch-change event channel: reader drives it as master, consumer as slave.
interface sw_reader_if #(
   parameter int unsigned WIDTH = 8
);
   logic             evt_valid;
   logic             evt_ready;
   logic [WIDTH-1:0] evt_value;
   logic [WIDTH-1:0] evt_rise;
   logic [WIDTH-1:0] evt_fall;
   logic             evt_overflow;

   modport master (
      output evt_valid,
      output evt_value,
      output evt_rise,
      output evt_fall,
      output evt_overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_value,
      input  evt_rise,
      input  evt_fall,
      input  evt_overflow,
      output evt_ready
   );
endinterface

// File: rtl/sw_reader_sync_chain.sv
// N-stage, WIDTH-bit flop synchronizer with synchronous active-high reset.
module sync_chain #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sw_reader.sv
// Switch-bus reader: synchronize, debounce, and emit one valid/ready event per committed change.
// Define SW_READER_EDGE_EN to build the rise/fall mask registers; otherwise they read as 0.
module sw_reader
   import sw_reader_pkg::*;
#(
   parameter int unsigned WIDTH           = SW_WIDTH,
   parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_SIM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] LED,
   output logic [WIDTH-1:0] sw_stable,
   sw_reader_if.master      evt
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync;

   sync_chain #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (WIDTH)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (SW),
      .q_o (sync)
   );

   sw_state_e        state_q, state_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic             commit;

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      commit   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sync != stable_q) begin
               cand_d  = sync;
               cnt_d   = CntW'(1);
               state_d = StPending;
            end
         end
         StPending: begin
            if (sync == stable_q) begin
               state_d = StIdle;
            end else if (sync != cand_q) begin
               cand_d = sync;
               cnt_d  = CntW'(1);
            end else if (cnt_q == CntLast) begin
               commit   = 1'b1;
               stable_d = cand_q;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Event buffer; a commit against a stalled entry merges into it.
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             ovf_q, ovf_d;
   logic             stalled;

   assign stalled = valid_q && !evt.evt_ready;

   always_comb begin
      valid_d = valid_q;
      value_d = value_q;
      ovf_d   = ovf_q;
      if (commit) begin
         valid_d = 1'b1;
         value_d = cand_q;
         if (stalled) begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && evt.evt_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
         valid_q  <= 1'b0;
         value_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef SW_READER_EDGE_EN
   logic [WIDTH-1:0] rise, fall;
   logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;

   assign rise = cand_q & ~stable_q;
   assign fall = ~cand_q & stable_q;

   always_comb begin
      rise_d = rise_q;
      fall_d = fall_q;
      if (commit) begin
         rise_d = stalled ? (rise_q | rise) : rise;
         fall_d = stalled ? (fall_q | fall) : fall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign evt.evt_rise = rise_q;
   assign evt.evt_fall = fall_q;
`else
   assign evt.evt_rise = '0;
   assign evt.evt_fall = '0;
`endif

   assign sw_stable        = stable_q;
   assign LED              = stable_q;
   assign evt.evt_valid    = valid_q;
   assign evt.evt_value    = value_q;
   assign evt.evt_overflow = ovf_q;

endmodule

// File: doc/sw_reader.md
# sw_reader

Synthesizable receiving end of the board switch bus: samples the asynchronous `SW` inputs, synchronizes and debounces them, and presents each committed change as a single-entry valid/ready event carrying the new value and per-bit rise/fall masks. It sits between the switch pins and downstream logic (the LED datapath and control FSMs). `LED` mirrors the debounced value for on-board inspection.

## Interface
- `WIDTH`, 8: switch bus width.
- `SYNC_STAGES`, 2: synchronizer flops, at least 2.
- `DEBOUNCE_CYCLES`, 4: consecutive equal samples required to commit, at least 2. Use 4 in simulation and about 1_000_000 on board.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SW` in WIDTH: raw switch inputs, asynchronous.
- `LED` out WIDTH: equals `sw_stable`.
- `sw_stable` out WIDTH: debounced value.
- `evt_valid` out 1: an event is pending.
- `evt_ready` in 1: consumer accepts the event.
- `evt_value` out WIDTH: committed value.
- `evt_rise` out WIDTH: bits that went 0→1.
- `evt_fall` out WIDTH: bits that went 1→0.
- `evt_overflow` out 1: sticky flag, set when events were coalesced.

## Operation
- Synchronizer: `SW` passes through a SYNC_STAGES chain. The last stage is `sync`. All stages reset to 0.
- Debounce FSM states: IDLE and PENDING. Registers: `cand` (WIDTH bits) and `cnt` (width $clog2(DEBOUNCE_CYCLES+1)).
- IDLE: if `sync` != `sw_stable`, set `cand`<=`sync`, set `cnt`<=1, and go to PENDING.
- PENDING:
  - If `sync` == `sw_stable`: go to IDLE with no event. This is a glitch reject.
  - Else if `sync` != `cand`: set `cand`<=`sync` and `cnt`<=1. This restarts the count.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: commit. Set `sw_stable`<=`cand` and go to IDLE.
  - Else: `cnt`++.
- On commit, compute rise = `cand` & ~`sw_stable` and fall = ~`cand` & `sw_stable`.
- Event buffer, one entry:
  - On commit, if the buffer is empty or is being accepted this cycle (`evt_valid`&&`evt_ready`): load `evt_value`=`cand`, `evt_rise`=rise, `evt_fall`=fall, and set `evt_valid`=1.
  - On commit while `evt_valid`&&!`evt_ready`: coalesce. Set `evt_value`<=`cand`, `evt_rise`|=rise, `evt_fall`|=fall, and `evt_overflow`<=1. `evt_valid` stays 1.
  - `evt_valid`&&`evt_ready` with no commit in the same cycle: `evt_valid`<=0.
- Handshake rule: `evt_value`, `evt_rise` and `evt_fall` are held stable while `evt_valid`&&!`evt_ready`, except when coalescing.
- `evt_overflow` is cleared only by `rst`.

## Timing
- Reset values: `sw_stable`, `LED`, `evt_valid`, `evt_value`, `evt_rise`, `evt_fall`, `evt_overflow` are all 0. The FSM is in IDLE, and the synchronizer and `cnt` are 0.
- Latency: a change of `SW` captured at edge k appears on `sw_stable`/`LED` after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. `evt_valid` rises on that same edge. With the defaults, this is edge k+5.
- Throughput: at most one commit per DEBOUNCE_CYCLES cycles. A consumer holding `evt_ready`=1 never causes coalescing.
- Reset mid-PENDING or with an event pending: all state is cleared on that edge and the event is lost. A nonzero `SW` held after reset produces a rise-only event once the latency has elapsed.

## Configuration
- `SW_READER_EDGE_EN` defined: rise/fall masks are computed, registered and coalesced as described in Operation.
- `SW_READER_EDGE_EN` undefined: the `evt_rise` and `evt_fall` ports remain but are tied to 0, and their registers are not built. All other behaviour is unchanged.

## Structure
- Package `sw_reader_pkg` holds:
  - the FSM state enum (IDLE, PENDING);
  - default constants SW_WIDTH=8, SW_SYNC_STAGES=2, SW_DEBOUNCE_SIM=4, SW_DEBOUNCE_BOARD=1_000_000.
- One sub-module, `sync_chain`: a parameterized N-stage, WIDTH-bit synchronizer with synchronous reset. Everything else lives in `sw_reader`.

## Test plan
All scenarios use the defaults (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4) and a 10 ns clock.
- Basic commit: reset with SW=00, release, set SW=02 at edge k and hold, `evt_ready`=1. Expected: `sw_stable`=02 after edge k+5; one event with value 02, rise 02, fall 00; `evt_valid` is high for exactly 1 cycle.
- Glitch reject: SW=01 for 2 cycles, then back to 00. Expected: no event, `sw_stable` stays 00, FSM returns to IDLE.
- Sweep: SW = 0,2,4…254, stepping every 5 cycles, `evt_ready`=1. Expected: exactly 127 events with values 02…FE in order and `evt_overflow`=0.
- Backpressure: `evt_ready`=0, SW 00→01, wait 10 cycles, then →03. Expected: a single pending event with value 03, rise 03, fall 00, and `evt_overflow`=1. Then assert `evt_ready` for 1 cycle. Expected: `evt_valid`=0 and `evt_overflow` still 1.
- Reset mid-operation: assert `rst` while in PENDING with an event pending. Expected: all outputs are 0 after that edge, and no event appears until SW changes again.
- Macro off: rerun the basic commit without `SW_READER_EDGE_EN`. Expected: identical `evt_value`/timing, and `evt_rise`=`evt_fall`=00.
